sram22_req_ctrl: RTL

- Front-end controller that sits directly upstream of the 64x24 SRAM22 macro (4-way column mux, 8-bit write granularity) and drives its clk-synchronous ce/we/wmask/addr/din pins.
- Converts a valid/ready request stream into macro accesses and captures macro read data into a small response FIFO with valid/ready back-pressure.
- Zero-initialises every word after reset.
- Hides the macro's 1-cycle read timing and lack of flow control from the client.

---
 rtl/sram22_ctrl_pkg.sv | 14 +
 rtl/sram22_rsp_fifo.sv | 71 +++++++
 rtl/sram22_req_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sram22_ctrl_pkg.sv
// Shared defaults and types for the SRAM22 request controller.
package sram22_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 6;
    localparam int unsigned DATA_WIDTH_DEF  = 24;
    localparam int unsigned WMASK_WIDTH_DEF = 3;
    localparam int unsigned LANE_WIDTH      = DATA_WIDTH_DEF / WMASK_WIDTH_DEF;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Circular response FIFO; the caller guarantees no push while full without a same-cycle pop
// and no pop while empty.
module sram22_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 24,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [OCC_W-1:0] occ,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign occ   = occ_q;
    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sram22_req_ctrl.sv
// Request front-end for the SRAM22 macro: zero-fills after reset, then maps a valid/ready
// request stream onto macro pins and buffers read data in a credit-controlled response FIFO.
module sram22_req_ctrl
    import sram22_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned WMASK_WIDTH = WMASK_WIDTH_DEF,
    parameter int unsigned RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   init_done,
    output logic                   sram_rstb,
    output logic                   sram_ce,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CRD_W = OCC_W + 1;

    ctrl_state_e         state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic                rd_inflight_q, rd_inflight_d;

    logic [OCC_W-1:0]    fifo_occ;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                pop;
    logic [CRD_W-1:0]    credit_used;

    assign sram_rstb = ~rst;
    assign init_done = init_done_q;
    assign rsp_valid = ~fifo_empty;
    assign pop       = rsp_valid & rsp_ready;
    assign fifo_push = rd_inflight_q & (~fifo_full | pop);

    // Buffered plus in-flight reads, less the one leaving this cycle; never underflows since
    // pop implies occ >= 1.
    assign credit_used = CRD_W'(fifo_occ) + CRD_W'(rd_inflight_q) - CRD_W'(pop);
    assign req_ready   = ~rst & (state_q == RUN) & (credit_used < CRD_W'(RSP_DEPTH));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        init_done_d   = init_done_q;
        rd_inflight_d = 1'b0;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d[ADDR_WIDTH]) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                rd_inflight_d = req_valid & req_ready & ~req_we;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= INIT;
            cnt_q         <= '0;
            init_done_q   <= 1'b0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_done_q   <= init_done_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    always_comb begin
        if (state_q == INIT) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_wmask = '1;
            sram_addr  = cnt_q[ADDR_WIDTH-1:0];
            sram_din   = '0;
        end else begin
            sram_ce    = req_valid & req_ready;
            sram_we    = req_we;
            sram_wmask = req_wmask;
            sram_addr  = req_addr;
            sram_din   = req_wdata;
        end
    end

    sram22_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (sram_dout),
        .pop   (pop),
        .rdata (rsp_rdata),
        .occ   (fifo_occ),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
